// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg: shared encodings and round-robin pick helper for edge_event_arbiter
package edge_evt_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PRESENT = 1'b1;
  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;
  // first set bit of req[n-1:0] scanning ptr, ptr+1, ... modulo n (ptr < n <= 32)
  function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
    int idx;
    rr_pick = 0;
    for (int k = 31; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx -= n;
        if (req[idx]) rr_pick = idx;
      end
    end
  endfunction
endpackage

// File: rtl/edge_event_arbiter_sync.sv
// edge_event_arbiter_sync: multi-flop synchronizer for one asynchronous line
//   clk, rst (async, active-high), async_in: raw line, sync_out: synchronized level
module edge_event_arbiter_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= '0;
    else ff <= {ff[SYNC_STAGES-2:0], async_in};
  assign sync_out = ff[SYNC_STAGES-1];
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: synchronizes async lines, captures edges and serializes them round-robin
//   clk, rst (async, active-high); async_in: raw lines; sync_level: synchronized levels
//   evt_valid/evt_ready/evt_id/evt_rise: event port; overflow: sticky lost-edge flags; ovf_clear: clears them
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int SYNC_STAGES = 3,
  localparam int ID_W = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] async_in,
  output logic [NUM_INPUTS-1:0] sync_level,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [ID_W-1:0]       evt_id,
  output logic                  evt_rise,
  output logic [NUM_INPUTS-1:0] overflow,
  input  logic                  ovf_clear
);
  logic [NUM_INPUTS-1:0] prev, pend_rise, pend_fall, ord, ord_n;
  logic [NUM_INPUTS-1:0] rise_t, fall_t, clr_r, clr_f, surv_r, surv_f, req;
  logic [ID_W-1:0] rr_ptr;
  logic state, state_n, acc;
  int sel;
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_sync
    edge_event_arbiter_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .async_in(async_in[g]), .sync_out(sync_level[g])
    );
  end
  assign rise_t = sync_level & ~prev;
  assign fall_t = ~sync_level & prev;
  assign acc = evt_valid & evt_ready;
  assign req = pend_rise | pend_fall;
  assign sel = rr_pick(32'(req), int'(rr_ptr), NUM_INPUTS);
  always_comb begin
    clr_r = '0;
    clr_f = '0;
    clr_r[evt_id] = acc & evt_rise;
    clr_f[evt_id] = acc & ~evt_rise;
  end
  // pend bits surviving this cycle's accept; a same-type tick on a survivor is coalesced
  assign surv_r = pend_rise & ~clr_r;
  assign surv_f = pend_fall & ~clr_f;
  // ord tracks the older edge: a lone survivor is the older one, a fresh tick on empty sets it
  assign ord_n = (surv_r & ~surv_f) | (surv_r & surv_f & ord) | (~surv_r & ~surv_f & rise_t);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  always_comb state_n = (state == ST_IDLE) ? (|req ? ST_PRESENT : ST_IDLE) : (evt_ready ? ST_IDLE : ST_PRESENT);
  always_comb evt_valid = (state == ST_PRESENT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= '0;
      pend_rise <= '0;
      pend_fall <= '0;
      ord <= '0;
      overflow <= '0;
      rr_ptr <= '0;
      evt_id <= '0;
      evt_rise <= EVT_FALL;
    end else begin
      prev <= sync_level;
      pend_rise <= rise_t | surv_r;
      pend_fall <= fall_t | surv_f;
      ord <= ord_n;
      overflow <= (overflow & {NUM_INPUTS{~ovf_clear}}) | (rise_t & surv_r) | (fall_t & surv_f);
      if (state == ST_IDLE && |req) begin
        evt_id <= ID_W'(sel);
        evt_rise <= pend_rise[sel] & (~pend_fall[sel] | ord[sel]);
      end
      if (acc) rr_ptr <= (int'(evt_id) == NUM_INPUTS - 1) ? '0 : evt_id + 1'b1;
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: randomized scoreboard bench with a queue-based reference model
module tb_edge_event_arbiter;
  localparam int N = 4;
  typedef struct {int id; bit rise;} ev_t;
  logic clk = 0, rst = 0, evt_ready = 0, ovf_clear = 0;
  logic [N-1:0] async_in = '0;
  logic [N-1:0] sync_level, overflow;
  logic evt_valid, evt_rise;
  logic [1:0] evt_id;
  int vectors = 0, errs = 0;
  ev_t exp_q[$];
  bit lst[N][$];
  bit m_busy = 0;
  int m_id = 0, m_rr = 0;
  logic [N-1:0] m_ovf = '0;
  logic [N-1:0] hist[5] = '{default: '0};
  bit held = 0;
  int h_id = 0;
  bit h_rise = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.NUM_INPUTS(N), .SYNC_STAGES(3)) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_level(sync_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_rise(evt_rise),
    .overflow(overflow), .ovf_clear(ovf_clear)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // reference model: per-input queue of pending edge types in arrival order
  always @(negedge clk) begin
    logic [N-1:0] new_ovf;
    bit t, dup;
    if (rst) begin
      chk("rst_valid", evt_valid, 0);
      chk("rst_overflow", overflow, 0);
      for (int i = 0; i < N; i++) lst[i].delete();
      exp_q.delete();
      m_busy = 0;
      m_rr = 0;
      m_ovf = '0;
      for (int k = 0; k < 5; k++) hist[k] = '0;
    end else begin
      for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = async_in;
      chk("sync_level", sync_level, hist[3]);
      chk("evt_valid", evt_valid, m_busy);
      chk("overflow", overflow, m_ovf);
      new_ovf = '0;
      if (m_busy && evt_ready) begin
        void'(lst[m_id].pop_front());
        m_busy = 0;
        m_rr = (m_id + 1) % N;
      end else if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (lst[j].size() > 0) begin
            m_busy = 1;
            m_id = j;
            exp_q.push_back('{j, lst[j][0]});
            break;
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (hist[3][i] != hist[4][i]) begin
          t = hist[3][i];
          dup = 0;
          foreach (lst[i][k]) if (lst[i][k] == t) dup = 1;
          if (dup) new_ovf[i] = 1;
          else lst[i].push_back(t);
        end
      m_ovf = (ovf_clear ? '0 : m_ovf) | new_ovf;
    end
  end

  // monitor: pops an expectation on each handshake; checks hold stability under backpressure
  always @(negedge clk) begin
    ev_t e;
    if (rst) held = 0;
    else begin
      if (evt_valid && held) begin
        chk("hold_id", evt_id, h_id);
        chk("hold_rise", evt_rise, h_rise);
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("evt_id", evt_id, e.id);
          chk("evt_rise", evt_rise, e.rise);
        end
      end
      held = evt_valid && !evt_ready;
      h_id = evt_id;
      h_rise = evt_rise;
    end
  end

  initial begin
    #1 rst = 1;
    for (int c = 0; c < 10; c++) begin
      async_in = N'($urandom);
      step(1);
    end
    async_in = '0;
    rst = 0;
    step(10);
    evt_ready = 1;
    async_in = 4'b0100;
    step(3);
    async_in = '0;
    step(15);
    async_in = 4'b1011;
    step(15);
    async_in = 4'b1000;
    step(5);
    async_in = 4'b1001;
    step(15);
    async_in = '0;
    step(15);
    evt_ready = 0;
    async_in = 4'b0110;
    step(3);
    async_in = '0;
    step(20);
    evt_ready = 1;
    step(20);
    evt_ready = 0;
    for (int p = 0; p < 2; p++) begin
      async_in[1] = 1;
      step(4);
      async_in[1] = 0;
      step(4);
    end
    step(5);
    evt_ready = 1;
    step(15);
    ovf_clear = 1;
    step(1);
    ovf_clear = 0;
    step(3);
    evt_ready = 0;
    async_in = 4'b0001;
    step(8);
    rst = 1;
    #1 chk("async_rst_valid", evt_valid, 0);
    step(1);
    async_in = '0;
    step(3);
    rst = 0;
    step(15);
    for (int c = 0; c < 3000; c++) begin
      int b;
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, N - 1);
        async_in[b] = ~async_in[b];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clear = ($urandom_range(0, 50) == 0);
      step(1);
    end
    evt_ready = 1;
    ovf_clear = 0;
    step(100);
    chk("drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
